// File: rtl/uart_rx_framer.sv
// UART receive framer: start detect, mid-bit sampling, LSB-first assembly and stop check.
// Define UART_RX_PARITY_EN to include a parity bit and the parity-checker strobe in each frame.
module uart_rx_framer #(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned CLOCKS_PER_BIT   = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        serial_in_synced,
   output logic [INPUT_DATA_WIDTH-1:0] received_data,
   output logic                        is_parity_stage,
   output logic                        data_valid,
   output logic                        framing_error,
   output logic                        busy
);

   localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(INPUT_DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INPUT_DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLOCKS_PER_BIT - 2);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;

`ifndef UART_RX_PARITY_EN
   assign is_parity_stage = 1'b0;
`endif

   // Framing FSM; counter restarts at every sample event so it never wraps mid-bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         idx           <= '0;
         received_data <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
         is_parity_stage <= 1'b0;
`endif
      end else begin
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         cnt           <= cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!serial_in_synced) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!serial_in_synced) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (cnt == FULL_LAST) begin
                  cnt           <= '0;
                  received_data <= {serial_in_synced, received_data[INPUT_DATA_WIDTH-1:1]};
                  if (idx == LAST_IDX) begin
                     idx <= '0;
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            // Strobe opens one cycle ahead of the parity sample and closes one cycle after.
            PARITY: begin
               if (cnt == PRE_LAST) begin
                  is_parity_stage <= 1'b1;
               end
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
`ifdef UART_RX_PARITY_EN
               is_parity_stage <= 1'b0;
`endif
               if (cnt == FULL_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (serial_in_synced) begin
                     data_valid <= 1'b1;
                  end else begin
                     framing_error <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer; frame timing follows UART_RX_PARITY_EN when defined.
module tb_uart_rx_framer;

   localparam int W    = 8;
   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int STOP_K = W + 2;
`else
   localparam int STOP_K = W + 1;
`endif
   localparam int NB             = STOP_K + 1;
   localparam int LAST_DATA_EDGE = HALF + W * CPB;
   localparam int PAR_EDGE       = HALF + (W + 1) * CPB;
   localparam int STOP_EDGE      = HALF + STOP_K * CPB;

   logic         clk = 1'b0;
   logic         reset;
   logic         line;
   logic [W-1:0] received_data;
   logic         is_parity_stage;
   logic         data_valid;
   logic         framing_error;
   logic         busy;

   int checks = 0;
   int errors = 0;

   uart_rx_framer #(
      .INPUT_DATA_WIDTH(W),
      .CLOCKS_PER_BIT  (CPB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .serial_in_synced(line),
      .received_data   (received_data),
      .is_parity_stage (is_parity_stage),
      .data_valid      (data_valid),
      .framing_error   (framing_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [NB-1:0] build(input logic [W-1:0] d, input logic stop_bit);
      logic [NB-1:0] b;
      b = '0;
      b[W:1] = d;
`ifdef UART_RX_PARITY_EN
      b[W+1] = ^d;
`endif
      b[NB-1] = stop_bit;
      return b;
   endfunction

   // Start bit begins right after the call; the line returns high after the stop sample.
   task automatic drive_frame(input logic [W-1:0] d, input logic stop_bit);
      logic [NB-1:0] b;
      b = build(d, stop_bit);
      for (int k = 0; k < NB - 1; k++) begin
         line = b[k];
         tick(CPB);
      end
      line = b[NB-1];
      tick(HALF + 1);
      line = 1'b1;
      tick(CPB - HALF - 1);
   endtask

   task automatic watch_frame(input string name, input logic [W-1:0] d, input logic good);
      int dv_n, fe_n, dv_at, fe_at, ps_n, ps_first, ps_last;
      logic [W-1:0] rd_last;
      logic busy_pre, busy_post;
      dv_n = 0; fe_n = 0; dv_at = -1; fe_at = -1; ps_n = 0; ps_first = -1; ps_last = -1;
      rd_last = '0; busy_pre = 1'b0; busy_post = 1'b1;
      tick(1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_e0: got %b expected 1", name, busy);
      end
      for (int e = 1; e <= STOP_EDGE + 1; e++) begin
         tick(1);
         if (data_valid === 1'b1) begin dv_n++; dv_at = e; end
         if (framing_error === 1'b1) begin fe_n++; fe_at = e; end
         if (is_parity_stage === 1'b1) begin
            ps_n++;
            if (ps_first < 0) ps_first = e;
            ps_last = e;
         end
         if (e == LAST_DATA_EDGE) rd_last = received_data;
         if (e == STOP_EDGE - 1) busy_pre = busy;
         if (e == STOP_EDGE) busy_post = busy;
      end
      checks++;
      if (rd_last !== d) begin
         errors++;
         $display("FAIL %s data_at_last_sample: got %h expected %h", name, rd_last, d);
      end
      checks++;
      if (received_data !== d) begin
         errors++;
         $display("FAIL %s data_after_stop: got %h expected %h", name, received_data, d);
      end
      checks++;
      if (dv_n != (good ? 1 : 0) || (good && dv_at != STOP_EDGE)) begin
         errors++;
         $display("FAIL %s data_valid: got %0d pulses at edge %0d expected %0d at edge %0d",
                  name, dv_n, dv_at, good ? 1 : 0, STOP_EDGE);
      end
      checks++;
      if (fe_n != (good ? 0 : 1) || (!good && fe_at != STOP_EDGE)) begin
         errors++;
         $display("FAIL %s framing_error: got %0d pulses at edge %0d expected %0d at edge %0d",
                  name, fe_n, fe_at, good ? 0 : 1, STOP_EDGE);
      end
      checks++;
      if (busy_pre !== 1'b1 || busy_post !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_around_stop: got %b/%b expected 1/0", name, busy_pre, busy_post);
      end
`ifdef UART_RX_PARITY_EN
      checks++;
      if (ps_n != 2 || ps_first != PAR_EDGE - 1 || ps_last != PAR_EDGE) begin
         errors++;
         $display("FAIL %s parity_stage: got %0d cycles %0d..%0d expected 2 cycles %0d..%0d",
                  name, ps_n, ps_first, ps_last, PAR_EDGE - 1, PAR_EDGE);
      end
`else
      checks++;
      if (ps_n != 0) begin
         errors++;
         $display("FAIL %s parity_stage: got %0d cycles expected 0 (edge %0d unused)",
                  name, ps_n, PAR_EDGE);
      end
`endif
   endtask

   task automatic run_frame(input string name, input logic [W-1:0] d, input logic stop_bit);
      fork
         drive_frame(d, stop_bit);
         watch_frame(name, d, stop_bit);
      join
   endtask

   task automatic test_reset;
      reset = 1'b1;
      line  = 1'b1;
      tick(3);
      checks++;
      if ({received_data, is_parity_stage, data_valid, framing_error, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%b%b%b%b expected all 0", received_data,
                  is_parity_stage, data_valid, framing_error, busy);
      end
      reset = 1'b0;
      tick(5);
      checks++;
      if (busy !== 1'b0 || received_data !== '0) begin
         errors++;
         $display("FAIL reset_idle: got busy %b data %h expected 0/00", busy, received_data);
      end
   endtask

   task automatic test_good_frame;
      run_frame("frame_a5", 8'hA5, 1'b1);
      tick(4);
      run_frame("frame_5a", 8'h5A, 1'b1);
      tick(4);
   endtask

   task automatic test_false_start;
      logic [W-1:0] rd_before;
      int pulses;
      rd_before = received_data;
      pulses = 0;
      line = 1'b0;
      tick(4);
      line = 1'b1;
      tick(4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL false_start_busy_before: got %b expected 1", busy);
      end
      tick(1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL false_start_busy_drop: got %b expected 0", busy);
      end
      for (int i = 0; i < 2 * CPB; i++) begin
         tick(1);
         if (data_valid === 1'b1 || framing_error === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || received_data !== rd_before) begin
         errors++;
         $display("FAIL false_start_quiet: got %0d active cycles data %h expected 0 data %h",
                  pulses, received_data, rd_before);
      end
   endtask

   task automatic test_framing_error;
      run_frame("frame_3c_bad_stop", 8'h3C, 1'b0);
      tick(4);
   endtask

   task automatic test_reset_mid_frame;
      logic [NB-1:0] b;
      b = build(8'h3C, 1'b1);
      for (int c = 0; c < 60; c++) begin
         line = b[c / CPB];
         tick(1);
      end
      checks++;
      if (busy !== 1'b1 || received_data === '0) begin
         errors++;
         $display("FAIL mid_frame_before_reset: got busy %b data %h expected 1 and nonzero",
                  busy, received_data);
      end
      tick(1);
      #2 reset = 1'b1;
      line = 1'b1;
      #1;
      checks++;
      if ({received_data, is_parity_stage, data_valid, framing_error, busy} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got %h/%b%b%b%b expected all 0", received_data,
                  is_parity_stage, data_valid, framing_error, busy);
      end
      tick(9);
      reset = 1'b0;
      tick(5);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_idle: got busy %b expected 0", busy);
      end
      run_frame("frame_3c_after_reset", 8'h3C, 1'b1);
      tick(4);
   endtask

   task automatic test_back_to_back;
      run_frame("b2b_00", 8'h00, 1'b1);
      run_frame("b2b_ff", 8'hFF, 1'b1);
      tick(4);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_false_start();
      test_framing_error();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
